// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types for the reset sequencer.
//   state_t : sequencer FSM states
//   cause_t : encoding reported on rst_cause
//   max_int : elaboration helper for counter sizing
package rst_seq_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'b00,
      RELEASE = 2'b01,
      RUN     = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_POR = 2'b00,
      CAUSE_SW  = 2'b01,
      CAUSE_WDT = 2'b10
   } cause_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rst_seq_wdt.sv
// rst_seq_wdt: watchdog counter for the reset sequencer.
// Only instantiated when RST_SEQ_WDT_EN is defined.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   active  in   count enable (sequencer in RUN and watchdog enabled)
//   kick    in   clears the count; a kick in the expiry cycle wins
//   expire  out  single-cycle pulse when the count reaches WDT_TIMEOUT-1 unkicked
import rst_seq_pkg::*;

module rst_seq_wdt #(
   parameter int WDT_TIMEOUT = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic kick,
   output logic expire
);

   localparam int WDT_W = $clog2(WDT_TIMEOUT + 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

   logic [WDT_W-1:0] wdt_cnt_q;
   logic [WDT_W-1:0] wdt_cnt_d;

   always_comb begin
      expire    = active && !kick && (wdt_cnt_q == WDT_LAST);
      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      // Expiry restarts the count too; the sequencer leaves RUN on that edge
      // anyway, so the counter is held at zero until RUN is reached again.
      if (!active || kick || expire) begin
         wdt_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_cnt_q <= '0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
      end
   end

endmodule

// File: rtl/rst_seq.sv
// rst_seq: reset generator and sequencer.
// Stretches every reset (POR, software request, watchdog expiry) to HOLD_CYC
// cycles, then releases the NUM_STAGES subsystem resets in order, GAP_CYC
// cycles apart. All outputs come straight from flops so the reset nets are
// glitch-free.
// Optional watchdog: define RST_SEQ_WDT_EN to build it. Without it the
// wdt_en / wdt_kick ports are ignored and rst_cause never reports WDT.
// Ports:
//   clk           in   system clock, posedge
//   rst_n         in   global reset, async assert, active-low
//   sw_rst_req    in   single-cycle software reset request
//   wdt_en        in   watchdog enable (level)
//   wdt_kick      in   watchdog kick pulse
//   stage_rst_n   out  sequenced active-low resets, bit 0 released first
//   all_released  out  high once every stage is released
//   rst_cause     out  cause of last reset: 00 POR, 01 SW, 10 WDT
//
// state   | meaning
// HOLD    | all stages in reset, counting the minimum assertion width
// RELEASE | stage 0 released, releasing the rest one per GAP_CYC cycles
// RUN     | all stages released, watchdog may run
import rst_seq_pkg::*;

module rst_seq #(
   parameter int NUM_STAGES  = 3,
   parameter int HOLD_CYC    = 16,
   parameter int GAP_CYC     = 4,
   parameter int WDT_TIMEOUT = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sw_rst_req,
   input  logic                  wdt_en,
   input  logic                  wdt_kick,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  all_released,
   output logic [1:0]            rst_cause
);

   localparam int CNT_W = $clog2(max_int(HOLD_CYC, GAP_CYC) + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
   logic [NUM_STAGES-1:0] stage_shift;
   logic                  all_released_q, all_released_d;
   cause_t                rst_cause_q, rst_cause_d;
   logic                  wdt_expire;

`ifdef RST_SEQ_WDT_EN
   rst_seq_wdt #(
      .WDT_TIMEOUT (WDT_TIMEOUT)
   ) u_wdt (
      .clk    (clk),
      .rst_n  (rst_n),
      .active ((state_q == RUN) && wdt_en),
      .kick   (wdt_kick),
      .expire (wdt_expire)
   );
`else
   localparam int unused_wdt_timeout = WDT_TIMEOUT;
   logic unused_wdt;
   assign unused_wdt = wdt_en ^ wdt_kick;
   assign wdt_expire = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stage_rst_n_d  = stage_rst_n_q;
      all_released_d = all_released_q;
      rst_cause_d    = rst_cause_q;

      // Stages fill from bit 0 upward, so shifting in a 1 is always "release
      // the next stage" and can never release out of order.
      stage_shift = (stage_rst_n_q << 1) | NUM_STAGES'(1);

      if (sw_rst_req || wdt_expire) begin
         state_d        = HOLD;
         cnt_d          = '0;
         stage_rst_n_d  = '0;
         all_released_d = 1'b0;
         rst_cause_d    = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
      end else begin
         case (state_q)
            HOLD, RELEASE: begin
               if (cnt_q == ((state_q == HOLD) ? HOLD_LAST : GAP_LAST)) begin
                  cnt_d         = '0;
                  stage_rst_n_d = stage_shift;
                  if (&stage_shift) begin
                     state_d        = RUN;
                     all_released_d = 1'b1;
                  end else begin
                     state_d = RELEASE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
            end
            default: begin
               // Unreachable encoding: restart the full sequence.
               state_d        = HOLD;
               cnt_d          = '0;
               stage_rst_n_d  = '0;
               all_released_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= HOLD;
         cnt_q          <= '0;
         stage_rst_n_q  <= '0;
         all_released_q <= 1'b0;
         rst_cause_q    <= CAUSE_POR;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stage_rst_n_q  <= stage_rst_n_d;
         all_released_q <= all_released_d;
         rst_cause_q    <= rst_cause_d;
      end
   end

   assign stage_rst_n  = stage_rst_n_q;
   assign all_released = all_released_q;
   assign rst_cause    = rst_cause_q;

endmodule
